// File: rtl/ldpc_3gpp_enc_mm_ppram.sv
// Ping-pong block buffer for the 3GPP LDPC encoder: two banks written linearly,
// read back as a circular word+bit shifted stream of the Zc-bit block.
module ldpc_3gpp_enc_mm_ppram #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8,
    parameter int pPIPE   = 0
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic                       iclkena,
    input  logic [pADDR_W:0]           iused_zc,
    input  logic                       iwrite,
    input  logic                       iwstart,
    input  logic [pDAT_W-1:0]          iwdat,
    input  logic                       irstart,
    input  logic                       irval,
    input  logic [pADDR_W-1:0]         irwshift,
    input  logic [$clog2(pDAT_W)-1:0]  irbshift,
    input  logic                       irmask,
    input  logic                       irshift_r,
    input  logic [3:0]                 irstrb,
    input  logic                       irelease,
    output logic                       owrdy,
    output logic                       ordrdy,
    output logic                       oval,
    output logic [3:0]                 ostrb,
    output logic [pDAT_W-1:0]          odat,
    output logic                       oerr
);

    localparam int cDEPTH = 2 ** pADDR_W;
    localparam int cZW    = pADDR_W + 1;
    localparam int cBS_W  = $clog2(pDAT_W);
    localparam int cLAT   = 3 + pPIPE;

    logic [pDAT_W-1:0]           mem_r [0:2*cDEPTH-1];
    logic [cZW-1:0]              zc_r  [0:1];
    logic [1:0]                  cnt_r;
    logic [1:0]                  cnt_nxt_s;
    logic                        wptr_r;
    logic                        rptr_r;
    logic [pADDR_W-1:0]          waddr_r;
    logic [pADDR_W-1:0]          raddr_r;
    logic [cBS_W-1:0]            bshift_r;
    logic                        shr_r;
    logic                        mask_r;
    logic                        wr_ok_s;
    logic                        full_s;
    logic                        rel_s;
    logic [pADDR_W-1:0]          wa_s;
    logic [cZW-1:0]              zc_w_s;
    logic [cZW-1:0]              zc_rd_s;
    logic [cZW-1:0]              ra_start_s;
    logic                        raddr_last_s;
    logic [pDAT_W-1:0]           rd_r;
    logic [pDAT_W-1:0]           rdp_s;
    logic [pDAT_W-1:0]           cur_r;
    logic [pDAT_W-1:0]           prv_r;
    logic [cLAT-1:0]             vd_r;
    logic [cLAT-1:0][3:0]        sd_r;

    // Window {current, previous}: left shift keeps the low word, right shift the high word.
    function automatic logic [pDAT_W-1:0] bit_shift(input logic [pDAT_W-1:0] cur,
                                                    input logic [pDAT_W-1:0] prv,
                                                    input logic [cBS_W-1:0]  bs,
                                                    input logic              shr);
        logic [2*pDAT_W-1:0] sh;
        if (shr) begin
            sh = {cur, prv} << bs;
            return sh[2*pDAT_W-1:pDAT_W];
        end else begin
            sh = {cur, prv} >> bs;
            return sh[pDAT_W-1:0];
        end
    endfunction

    assign wr_ok_s      = iwrite & ~cnt_r[1];
    assign wa_s         = iwstart ? '0 : waddr_r;
    assign zc_w_s       = iwstart ? iused_zc : zc_r[wptr_r];
    assign full_s       = wr_ok_s & ({1'b0, wa_s} == (zc_w_s - cZW'(1)));
    assign rel_s        = irelease & (cnt_r != 2'd0);
    assign zc_rd_s      = zc_r[rptr_r];
    assign ra_start_s   = irshift_r ? (zc_rd_s - cZW'(1) - {1'b0, irwshift}) : {1'b0, irwshift};
    assign raddr_last_s = ({1'b0, raddr_r} == (zc_rd_s - cZW'(1)));

    // Occupancy update: a fill and a release in the same cycle cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({full_s, rel_s})
            2'b10:   cnt_nxt_s = cnt_r + 2'd1;
            2'b01:   cnt_nxt_s = cnt_r - 2'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Bank control, read addressing and error flag.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            cnt_r    <= 2'd0;
            owrdy    <= 1'b1;
            ordrdy   <= 1'b0;
            wptr_r   <= 1'b0;
            rptr_r   <= 1'b0;
            waddr_r  <= '0;
            raddr_r  <= '0;
            bshift_r <= '0;
            shr_r    <= 1'b0;
            mask_r   <= 1'b0;
            oerr     <= 1'b0;
        end else if (iclkena) begin
            cnt_r  <= cnt_nxt_s;
            owrdy  <= ~cnt_nxt_s[1];
            ordrdy <= (cnt_nxt_s != 2'd0);
            oerr   <= (iwrite & cnt_r[1]) | (irstart & (cnt_r == 2'd0));
            if (full_s)
                wptr_r <= ~wptr_r;
            if (rel_s)
                rptr_r <= ~rptr_r;
            if (wr_ok_s)
                waddr_r <= full_s ? '0 : (wa_s + pADDR_W'(1));
            if (irstart) begin
                raddr_r  <= ra_start_s[pADDR_W-1:0];
                bshift_r <= irbshift;
                shr_r    <= irshift_r;
                mask_r   <= irmask;
            end else if (irval) begin
                raddr_r <= raddr_last_s ? '0 : (raddr_r + pADDR_W'(1));
            end
        end
    end

    // Bank storage: one write and one read port, contents survive reset.
    always_ff @(posedge iclk) begin
        if (iclkena && !ireset) begin
            if (wr_ok_s)
                mem_r[{wptr_r, wa_s}] <= iwdat;
            if (wr_ok_s && iwstart)
                zc_r[wptr_r] <= iused_zc;
        end
        if (iclkena && irval)
            rd_r <= mem_r[{rptr_r, raddr_r}];
    end

    if (pPIPE != 0) begin : g_pipe
        logic [pDAT_W-1:0] rdp_r;
        // Extra read-data register for timing closure on large banks.
        always_ff @(posedge iclk) begin
            if (iclkena)
                rdp_r <= rd_r;
        end
        assign rdp_s = rdp_r;
    end else begin : g_nopipe
        assign rdp_s = rd_r;
    end

    // Valid/strobe delay line, word history and the shifted output word.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            vd_r <= '0;
            sd_r <= '0;
            odat <= '0;
        end else if (iclkena) begin
            vd_r <= {vd_r[cLAT-2:0], irval};
            sd_r <= {sd_r[cLAT-2:0], irstrb};
            if (vd_r[pPIPE]) begin
                cur_r <= rdp_s;
                prv_r <= cur_r;
            end
            if (vd_r[pPIPE+1])
                odat <= mask_r ? '0 : bit_shift(cur_r, prv_r, bshift_r, shr_r);
        end
    end

    assign oval  = vd_r[cLAT-1];
    assign ostrb = sd_r[cLAT-1];

endmodule
